// File: rtl/merge2_rr.sv
// merge2_rr: two-channel round-robin stream merger feeding a one-entry
// registered output stage. Drives the mux2-style select for in*_data.
module merge2_rr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   localparam logic EMPTY = 1'b0;
   localparam logic FULL  = 1'b1;

   logic state;
   logic last;
   logic load_en;
   logic accept;

   // Grant: a lone requester wins; otherwise the channel not served last.
   always_comb begin
      sel = ~last;
      if (in0_valid && !in1_valid)
         sel = 1'b0;
      else if (in1_valid && !in0_valid)
         sel = 1'b1;
   end

   // Output register can take a word when empty or being drained this cycle.
   always_comb begin
      load_en   = (state == EMPTY) | out_ready;
      in0_ready = rst_n & load_en & ~sel;
      in1_ready = rst_n & load_en & sel;
      accept    = (in0_valid & in0_ready) | (in1_valid & in1_ready);
   end

   assign out_valid = (state == FULL);

   // Capture the granted word; remember who was served for round-robin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_data <= '0;
         last     <= 1'b1;
      end else if (accept) begin
         state    <= FULL;
         out_data <= sel ? in1_data : in0_data;
         last     <= sel;
      end else if (out_ready) begin
         state    <= EMPTY;
      end
   end

endmodule

// File: tb/tb_merge2_rr.sv
// Self-checking bench for merge2_rr: directed scenarios plus a randomized
// run, all compared against a transaction-level reference model.
module tb_merge2_rr;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             in0_valid;
   logic [WIDTH-1:0] in0_data;
   logic             in0_ready;
   logic             in1_valid;
   logic [WIDTH-1:0] in1_data;
   logic             in1_ready;
   logic             sel;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   int checks = 0;
   int errors = 0;

   // Reference model: contents of the output slot and who was served last.
   bit         m_valid;
   bit [7:0]   m_data;
   bit         m_last;
   bit [7:0]   sent[$];

   merge2_rr #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit exp_sel();
      if (in0_valid && !in1_valid) return 1'b0;
      if (in1_valid && !in0_valid) return 1'b1;
      return !m_last;
   endfunction

   function automatic bit slot_free();
      return rst_n && (!m_valid || out_ready);
   endfunction

   function automatic bit exp_r0();
      return slot_free() && !exp_sel();
   endfunction

   function automatic bit exp_r1();
      return slot_free() && exp_sel();
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_last  = 1'b1;
      sent.delete();
   endtask

   // Advance the model by one transfer cycle, then clock the DUT.
   task automatic tick();
      bit s;
      bit a0;
      bit a1;
      s  = exp_sel();
      a0 = in0_valid && exp_r0();
      a1 = in1_valid && exp_r1();
      if (a0 || a1) begin
         m_data  = s ? in1_data : in0_data;
         m_valid = 1'b1;
         m_last  = s;
         sent.push_back(m_data);
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      in0_data  = '0;
      in1_data  = '0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      out_ready = 1'b1;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      out_ready = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_init out_valid=%b out_data=%h expected 0/00", out_valid, out_data);
      end
      checks++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready in0_ready=%b in1_ready=%b expected 0/0", in0_ready, in1_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // load a word, then reset mid-cycle while it is held
      in0_valid = 1'b1;
      in0_data  = 8'h77;
      tick();
      in0_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h77) begin
         errors++;
         $display("FAIL reset_preload out_valid=%b out_data=%h expected 1/77", out_valid, out_data);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_async out_valid=%b out_data=%h rdy=%b%b expected 0/00/00",
                  out_valid, out_data, in0_ready, in1_ready);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      in0_data  = 8'h01;
      in1_data  = 8'h02;
      #1;
      checks++;
      if (sel !== 1'b0 || in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_grant sel=%b rdy=%b%b expected 0/10", sel, in0_ready, in1_ready);
      end
      idle_inputs();
   endtask

   task automatic test_single();
      bit [7:0] words [3];
      words[0] = 8'h11;
      words[1] = 8'h22;
      words[2] = 8'h33;
      reset_dut();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in0_valid = 1'b1;
         in0_data  = words[i];
         #1;
         checks++;
         if (sel !== 1'b0 || in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_grant[%0d] sel=%b rdy=%b%b expected 0/10", i, sel, in0_ready, in1_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== words[i]) begin
            errors++;
            $display("FAIL single_out[%0d] out=%b/%h expected 1/%h", i, out_valid, out_data, words[i]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_contention();
      bit [7:0] expv [6];
      bit [7:0] i0;
      bit [7:0] i1;
      expv[0] = 8'hA0; expv[1] = 8'hB0; expv[2] = 8'hA1;
      expv[3] = 8'hB1; expv[4] = 8'hA2; expv[5] = 8'hB2;
      reset_dut();
      out_ready = 1'b1;
      i0 = 8'hA0;
      i1 = 8'hB0;
      for (int k = 0; k < 6; k++) begin
         in0_valid = 1'b1;
         in1_valid = 1'b1;
         in0_data  = i0;
         in1_data  = i1;
         #1;
         if (exp_r0()) i0++;
         if (exp_r1()) i1++;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== expv[k]) begin
            errors++;
            $display("FAIL contention[%0d] out=%b/%h expected 1/%h", k, out_valid, out_data, expv[k]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      reset_dut();
      out_ready = 1'b0;
      in0_valid = 1'b1;
      in0_data  = 8'h5A;
      tick();
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      in0_data  = 8'hC0;
      in1_data  = 8'hD0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (in0_ready !== 1'b0 || in1_ready !== 1'b0 || sel !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall[%0d] rdy=%b%b sel=%b expected 00/1", k, in0_ready, in1_ready, sel);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            errors++;
            $display("FAIL bp_hold[%0d] out=%b/%h expected 1/5a", k, out_valid, out_data);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_release rdy=%b%b expected 01", in0_ready, in1_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hD0) begin
         errors++;
         $display("FAIL bp_next out=%b/%h expected 1/d0", out_valid, out_data);
      end
      idle_inputs();
   endtask

   task automatic test_drain();
      out_ready = 1'b1;
      idle_inputs();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty out_valid=%b expected 0", out_valid);
      end
      in1_valid = 1'b1;
      in1_data  = 8'hE7;
      #1;
      checks++;
      if (in1_ready !== 1'b1 || sel !== 1'b1) begin
         errors++;
         $display("FAIL drain_grant in1_ready=%b sel=%b expected 1/1", in1_ready, sel);
      end
      tick();
      in1_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hE7) begin
         errors++;
         $display("FAIL drain_refill out=%b/%h expected 1/e7", out_valid, out_data);
      end
      tick();
   endtask

   // Random traffic with simultaneous drain/refill; scoreboard on order.
   task automatic test_back_to_back();
      bit a0;
      bit a1;
      bit [7:0] want;
      reset_dut();
      for (int k = 0; k < 400; k++) begin
         #1;
         checks++;
         if (sel !== exp_sel() || in0_ready !== exp_r0() || in1_ready !== exp_r1()) begin
            errors++;
            $display("FAIL rand_ctrl[%0d] sel=%b rdy=%b%b expected %b/%b%b",
                     k, sel, in0_ready, in1_ready, exp_sel(), exp_r0(), exp_r1());
         end
         checks++;
         if (out_valid !== m_valid || (m_valid && out_data !== m_data)) begin
            errors++;
            $display("FAIL rand_out[%0d] out=%b/%h expected %b/%h", k, out_valid, out_data, m_valid, m_data);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sent.size() == 0) begin
               errors++;
               $display("FAIL rand_dup[%0d] out_data=%h expected no word", k, out_data);
            end else begin
               want = sent.pop_front();
               if (out_data !== want) begin
                  errors++;
                  $display("FAIL rand_order[%0d] out_data=%h expected %h", k, out_data, want);
               end
            end
         end
         a0 = in0_valid && exp_r0();
         a1 = in1_valid && exp_r1();
         tick();
         if (!(in0_valid && !a0 && $urandom_range(7) != 0)) begin
            in0_valid = ($urandom_range(3) != 0);
            in0_data  = 8'($urandom);
         end
         if (!(in1_valid && !a1 && $urandom_range(7) != 0)) begin
            in1_valid = ($urandom_range(3) != 0);
            in1_data  = 8'($urandom);
         end
         out_ready = ($urandom_range(3) != 0);
      end
      idle_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      idle_inputs();
      model_reset();
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_drain();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
